// File: rtl/fd_stencil_engine.sv
// fd_stencil_engine
//   One explicit heat-equation sweep over an NX x NY grid per i_start.
//   Interior cells: c + (((N+S+W+E) - 4c) >>> SHIFT), saturated to WIDTH.
//   Boundary cells are copied unchanged.
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous reset, active-low
//   i_start    one-cycle start pulse, only honoured in IDLE
//   o_addr_rd  source RAM read address (registered)
//   i_data     source RAM read data, combinational from o_addr_rd
//   o_we       destination RAM write enable (WR state only)
//   o_addr_wr  destination RAM write address
//   o_data     destination RAM write data
//   o_busy     sweep in progress
//   o_done     one-cycle completion pulse
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | waiting for i_start
// RD_C   | read centre cell, decide boundary vs interior
// RD_N   | read north neighbour (idx-NX)
// RD_S   | read south neighbour (idx+NX)
// RD_W   | read west neighbour  (idx-1)
// RD_E   | read east neighbour  (idx+1), form the result
// WR     | write result, advance to next cell
// DONE   | completion pulse
module fd_stencil_engine #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int NX         = 64,
  parameter int NY         = 64,
  parameter int SHIFT      = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  output logic [ADDR_WIDTH-1:0] o_addr_rd,
  input  logic [WIDTH-1:0]      i_data,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr_wr,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int XW = (NX > 1) ? $clog2(NX) : 1;
  localparam int YW = (NY > 1) ? $clog2(NY) : 1;
  localparam int AW = WIDTH + 4;

  localparam logic signed [AW-1:0] SAT_MAX = {5'b00000, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {5'b11111, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_RD_C, S_RD_N, S_RD_S, S_RD_W, S_RD_E, S_WR, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [XW-1:0]         x_q;
  logic [YW-1:0]         y_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] addr_rd_q;
  logic [ADDR_WIDTH-1:0] addr_wr_q;
  logic [WIDTH-1:0]      data_q;
  logic signed [WIDTH-1:0] c_q;
  logic signed [AW-1:0]  sum_q;

  logic                  boundary;
  logic                  last_cell;
  logic signed [AW-1:0]  c_ext;
  logic signed [AW-1:0]  n_ext;
  logic signed [AW-1:0]  d_full;
  logic signed [AW-1:0]  r_full;
  logic [WIDTH-1:0]      r_sat;

  assign boundary  = (x_q == '0) || (x_q == XW'(NX-1)) ||
                     (y_q == '0) || (y_q == YW'(NY-1));
  assign last_cell = (x_q == XW'(NX-1)) && (y_q == YW'(NY-1));

  // Stencil arithmetic in WIDTH+4 bits: the sum of four neighbours and 4*c
  // each need two extra bits, the difference one more.
  assign c_ext  = {{4{c_q[WIDTH-1]}}, c_q};
  assign n_ext  = {{4{i_data[WIDTH-1]}}, i_data};
  assign d_full = (sum_q + n_ext) - (c_ext <<< 2);
  assign r_full = c_ext + (d_full >>> SHIFT);

  always_comb begin
    r_sat = r_full[WIDTH-1:0];
    if (r_full > SAT_MAX)      r_sat = SAT_MAX[WIDTH-1:0];
    else if (r_full < SAT_MIN) r_sat = SAT_MIN[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_RD_C;
      S_RD_C: state_d = boundary ? S_WR : S_RD_N;
      S_RD_N: state_d = S_RD_S;
      S_RD_S: state_d = S_RD_W;
      S_RD_W: state_d = S_RD_E;
      S_RD_E: state_d = S_WR;
      S_WR:   state_d = last_cell ? S_DONE : S_RD_C;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: each read address is loaded on the transition into the state
  // that uses it, so it is stable for the whole read cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_q       <= '0;
      y_q       <= '0;
      idx_q     <= '0;
      addr_rd_q <= '0;
      addr_wr_q <= '0;
      data_q    <= '0;
      c_q       <= '0;
      sum_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            x_q       <= '0;
            y_q       <= '0;
            idx_q     <= '0;
            addr_rd_q <= '0;
          end
        end
        S_RD_C: begin
          c_q <= i_data;
          if (boundary) begin
            addr_wr_q <= idx_q;
            data_q    <= i_data;
          end else begin
            addr_rd_q <= idx_q - ADDR_WIDTH'(NX);
          end
        end
        S_RD_N: begin
          sum_q     <= n_ext;
          addr_rd_q <= idx_q + ADDR_WIDTH'(NX);
        end
        S_RD_S: begin
          sum_q     <= sum_q + n_ext;
          addr_rd_q <= idx_q - ADDR_WIDTH'(1);
        end
        S_RD_W: begin
          sum_q     <= sum_q + n_ext;
          addr_rd_q <= idx_q + ADDR_WIDTH'(1);
        end
        S_RD_E: begin
          addr_wr_q <= idx_q;
          data_q    <= r_sat;
        end
        S_WR: begin
          if (!last_cell) begin
            idx_q     <= idx_q + ADDR_WIDTH'(1);
            addr_rd_q <= idx_q + ADDR_WIDTH'(1);
            if (x_q == XW'(NX-1)) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    o_we      = (state_q == S_WR);
    o_done    = (state_q == S_DONE);
    o_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
    o_addr_rd = addr_rd_q;
    o_addr_wr = addr_wr_q;
    o_data    = data_q;
  end

endmodule

// File: tb/tb_fd_stencil_engine.sv
module tb_fd_stencil_engine;

  logic clk;
  logic rst_n;
  logic start;
  bit   active;          // 0: 32-bit instance under test, 1: 8-bit instance

  longint src [16];

  logic        start_a, start_b;
  logic [11:0] addr_rd_a, addr_wr_a, addr_rd_b, addr_wr_b;
  logic signed [31:0] din_a, dout_a;
  logic signed [7:0]  din_b, dout_b;
  logic we_a, busy_a, done_a, we_b, busy_b, done_b;

  typedef struct {
    int     addr;
    longint data;
  } exp_t;

  exp_t qe [$];

  int n_chk  = 0;
  int n_pass = 0;
  int n_busy = 0;
  int n_done = 0;
  int n_wr   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign start_a = start & ~active;
  assign start_b = start &  active;
  assign din_a = (addr_rd_a < 12'd16) ? src[addr_rd_a[3:0]][31:0] : 32'sd0;
  assign din_b = (addr_rd_b < 12'd16) ? src[addr_rd_b[3:0]][7:0]  : 8'sd0;

  fd_stencil_engine #(.WIDTH(32), .ADDR_WIDTH(12), .NX(4), .NY(4), .SHIFT(2)) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a),
    .o_addr_rd(addr_rd_a), .i_data(din_a),
    .o_we(we_a), .o_addr_wr(addr_wr_a), .o_data(dout_a),
    .o_busy(busy_a), .o_done(done_a)
  );

  fd_stencil_engine #(.WIDTH(8), .ADDR_WIDTH(12), .NX(4), .NY(4), .SHIFT(2)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b),
    .o_addr_rd(addr_rd_b), .i_data(din_b),
    .o_we(we_b), .o_addr_wr(addr_wr_b), .o_data(dout_b),
    .o_busy(busy_b), .o_done(done_b)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Reference model: floor division by 4 written out, then clamp to width w.
  function automatic longint model_cell(input int i, input int w);
    int x, y;
    longint d, q, r, lo, hi;
    x = i % 4;
    y = i / 4;
    if (x == 0 || x == 3 || y == 0 || y == 3) return src[i];
    d = src[i-4] + src[i+4] + src[i-1] + src[i+1] - 4 * src[i];
    if (d >= 0) q = d / 4;
    else        q = -((-d + 3) / 4);
    r  = src[i] + q;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r;
  endfunction

  task automatic push_exp();
    exp_t e;
    for (int i = 0; i < 16; i++) begin
      e.addr = i;
      e.data = model_cell(i, active ? 8 : 32);
      qe.push_back(e);
    end
  endtask

  task automatic wr_seen(input bit which, input int addr, input longint d);
    exp_t e;
    n_wr++;
    chk("wr_instance", longint'(which), longint'(active));
    if (qe.size() == 0) begin
      chk("wr_unexpected", 1, 0);
    end else begin
      e = qe.pop_front();
      chk("wr_addr", addr, e.addr);
      chk("wr_data", d, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (busy_a || busy_b) n_busy++;
    if (done_a || done_b) n_done++;
    if (we_a) wr_seen(1'b0, int'(addr_wr_a), longint'(dout_a));
    if (we_b) wr_seen(1'b1, int'(addr_wr_b), longint'(dout_b));
  end

  task automatic sweep(input int restart_at, input int rst_at);
    bit fired   = 1'b0;
    bit aborted = 1'b0;
    n_busy = 0;
    n_done = 0;
    n_wr   = 0;
    qe.delete();
    push_exp();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int cyc = 0; cyc < 200 && n_done == 0; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (restart_at >= 0 && !fired && n_busy == restart_at) begin
        start = 1'b1;
        fired = 1'b1;
      end
      if (rst_at >= 0 && n_busy == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_busy", active ? busy_b : busy_a, 0);
        chk("abort_we",   active ? we_b   : we_a,   0);
        chk("abort_done", active ? done_b : done_a, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        qe.delete();
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_done", n_done, 0);
        chk("abort_idle", active ? busy_b : busy_a, 0);
        aborted = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("sweep_done_seen", longint'(n_done > 0), 1);
      chk("busy_cycles", n_busy, 48);
      chk("done_pulses", n_done, 1);
      chk("write_count", n_wr, 16);
      chk("queue_drained", qe.size(), 0);
      repeat (6) @(posedge clk);
      #1;
      chk("stays_idle", n_busy, 48);
    end
  endtask

  task automatic fill(input longint v);
    for (int i = 0; i < 16; i++) src[i] = v;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 16; i++) src[i] = longint'($urandom_range(0, 4000)) - 2000;
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    active = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    busy_a,    0);
    chk("rst_we",      we_a,      0);
    chk("rst_done",    done_a,    0);
    chk("rst_addr_rd", addr_rd_a, 0);
    chk("rst_addr_wr", addr_wr_a, 0);
    chk("rst_data",    dout_a,    0);
    chk("rst_busy_b",  busy_b,    0);
    rst_n = 1'b1;

    fill(100);
    sweep(-1, -1);

    fill(0);
    src[5] = 1000;
    sweep(-1, -1);

    fill(0);
    src[6] = -1;
    sweep(-1, -1);

    fill_rand();
    sweep(10, -1);

    fill_rand();
    sweep(-1, 20);
    fill_rand();
    sweep(-1, -1);

    active = 1'b1;
    fill(0);
    src[5] = 100;
    src[1] = 127; src[4] = 127; src[6] = 127; src[9] = 127;
    sweep(-1, -1);

    fill(0);
    src[5] = -100;
    src[1] = -128; src[4] = -128; src[6] = -128; src[9] = -128;
    sweep(-1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
